// File: rtl/asl_seq_shifter.sv
// Sequential arithmetic left shifter: one bit per clock, start/busy/done handshake, sticky overflow.
// Optional feature: define ASL_SAT_EN to saturate the result to signed min/max when overflow occurred.
module asl_seq_shifter #(
  parameter int N   = 8,
  parameter int SHW = $clog2(N + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   din,
  input  logic [SHW-1:0] shamt,
  output logic [N-1:0]   dout,
  output logic           busy,
  output logic           done,
  output logic           ovf
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [SHW-1:0] NMAX = SHW'(N);

  state_t         r_state;
  state_t         w_nextState;
  logic [N-1:0]   r_dout;
  logic [SHW-1:0] r_cnt;
  logic           r_ovf;
  logic           w_accept;
  logic [SHW-1:0] w_shamtEff;
`ifdef ASL_SAT_EN
  logic           r_sign;
`endif

  always_comb begin
    w_accept   = start && (r_state != SHIFT);
    w_shamtEff = (shamt > NMAX) ? NMAX : shamt;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = SHIFT;
      SHIFT:   if (r_cnt == '0) w_nextState = DONE;
      DONE:    w_nextState = w_accept ? SHIFT : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // A sign change on any single step is exactly the condition for the true product to overflow N bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
`ifdef ASL_SAT_EN
      r_sign <= 1'b0;
`endif
    end else if (w_accept) begin
      r_dout <= din;
      r_cnt  <= w_shamtEff;
      r_ovf  <= 1'b0;
`ifdef ASL_SAT_EN
      r_sign <= din[N-1];
`endif
    end else if (r_state == SHIFT) begin
      if (r_cnt != '0) begin
        r_ovf  <= r_ovf | (r_dout[N-1] ^ r_dout[N-2]);
        r_dout <= {r_dout[N-2:0], 1'b0};
        r_cnt  <= r_cnt - SHW'(1);
      end
`ifdef ASL_SAT_EN
      else if (r_ovf) begin
        r_dout <= r_sign ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      end
`endif
    end
  end

  always_comb begin
    dout = r_dout;
    ovf  = r_ovf;
    busy = (r_state == SHIFT);
    done = (r_state == DONE);
  end

endmodule
